// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_e     : which requester owns the outstanding memory request
//   DEF_ADDR_W / DEF_DATA_W : default bus widths
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: one request channel and one response channel.
//   master : the arbiter (drives request fields, receives ready/response)
//   slave  : the single-port memory
// Handshake: a request transfers on a rising clk edge where mem_req_valid and
// mem_req_ready are both high; while valid is high and ready is low the
// request fields hold steady. mem_rsp_valid is a one-cycle pulse, exactly one
// per accepted request (stores included), carrying mem_rdata.
interface mem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_arb_grant.sv
// Priority select between fetch (if) and load/store (ls) with a starvation guard.
//   clk, reset    : clock, synchronous active-high reset
//   idle          : arbiter can accept a request this cycle
//   if_req_valid  : fetch request pending
//   ls_req_valid  : load/store request pending
//   grant_valid   : a request is accepted this cycle
//   grant_owner   : which requester is accepted
// ls normally wins; once ls has been granted STARVE_LIMIT times in a row while
// fetch kept waiting, fetch takes the next grant.
module arb_grant
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   idle,
  input  logic   if_req_valid,
  input  logic   ls_req_valid,
  output logic   grant_valid,
  output owner_e grant_owner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  always_comb begin
    starved     = if_req_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_valid = idle && (if_req_valid || ls_req_valid);
    grant_owner = (ls_req_valid && !starved) ? OWN_LS : OWN_IF;
  end

  // The streak only counts while fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req_valid) begin
      starve_cnt <= '0;
    end else if (grant_valid && grant_owner == OWN_IF) begin
      starve_cnt <= '0;
    end else if (grant_valid && grant_owner == OWN_LS &&
                 starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (if_*) and
// load/store (ls_*). One request is outstanding at a time.
//   clk, reset          : clock, synchronous active-high reset
//   if_req_valid/ready  : fetch request handshake, if_addr
//   if_rsp_valid        : 1-cycle fetch response pulse with if_rdata, if_rsp_err
//   ls_req_valid/ready  : load/store handshake, ls_addr, ls_we, ls_wdata, ls_wstrb
//   ls_rsp_valid        : 1-cycle response pulse with ls_rdata (0 for stores), ls_rsp_err
//   mem                 : memory bus (master side)
//   dbg_state           : current FSM state
// Requester handshakes: a request is taken in a cycle where *_req_valid and
// *_req_ready are both high; ready is combinational and only ever high in
// IDLE for the granted requester. Round trip is at least 3 cycles.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rsp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_rsp_err,
  mem_arbiter_if.master       mem,
  output arb_state_e          dbg_state
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e        state;
  owner_e            owner;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              grant_valid;
  owner_e            grant_owner;
  logic              rsp_done;
  logic              rsp_err_n;
  logic [DATA_W-1:0] rsp_data_n;

  arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk          (clk),
    .reset        (reset),
    .idle         (state == IDLE),
    .if_req_valid (if_req_valid),
    .ls_req_valid (ls_req_valid),
    .grant_valid  (grant_valid),
    .grant_owner  (grant_owner)
  );

  always_comb begin
    if_req_ready = grant_valid && (grant_owner == OWN_IF);
    ls_req_ready = grant_valid && (grant_owner == OWN_LS);
    // A real response wins if it lands on the last timeout cycle.
    rsp_done     = (state == WAIT) &&
                   (mem.mem_rsp_valid || tmo_cnt == TMO_W'(TIMEOUT - 1));
    rsp_err_n    = !mem.mem_rsp_valid;
    rsp_data_n   = (mem.mem_rsp_valid && !mem.mem_we) ? mem.mem_rdata : '0;
    dbg_state    = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      owner             <= OWN_IF;
      tmo_cnt           <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_we        <= 1'b0;
      mem.mem_wdata     <= '0;
      mem.mem_wstrb     <= '0;
      if_rsp_valid      <= 1'b0;
      if_rdata          <= '0;
      if_rsp_err        <= 1'b0;
      ls_rsp_valid      <= 1'b0;
      ls_rdata          <= '0;
      ls_rsp_err        <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner             <= grant_owner;
            mem.mem_req_valid <= 1'b1;
            state             <= ISSUE;
            if (grant_owner == OWN_LS) begin
              mem.mem_addr  <= ls_addr;
              mem.mem_we    <= ls_we;
              mem.mem_wdata <= ls_wdata;
              mem.mem_wstrb <= ls_wstrb;
            end else begin
              mem.mem_addr  <= if_addr;
              mem.mem_we    <= 1'b0;
              mem.mem_wdata <= '0;
              mem.mem_wstrb <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            tmo_cnt           <= '0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_done) begin
            state <= IDLE;
            if (owner == OWN_IF) begin
              if_rsp_valid <= 1'b1;
              if_rdata     <= rsp_data_n;
              if_rsp_err   <= rsp_err_n;
            end else begin
              ls_rsp_valid <= 1'b1;
              ls_rdata     <= rsp_data_n;
              ls_rsp_err   <= rsp_err_n;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          if_req_valid = 1'b0, if_req_ready;
  logic [AW-1:0] if_addr = '0;
  logic          if_rsp_valid, if_rsp_err;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid = 1'b0, ls_req_ready;
  logic [AW-1:0] ls_addr = '0;
  logic          ls_we = 1'b0;
  logic [DW-1:0] ls_wdata = '0;
  logic [3:0]    ls_wstrb = '0;
  logic          ls_rsp_valid, ls_rsp_err;
  logic [DW-1:0] ls_rdata;
  arb_state_e    dbg_state;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_rsp_err(ls_rsp_err),
    .mem(mem_bus.master), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_true(input string name, input logic cond);
    vectors++;
    if (cond !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: condition false, expected true (cycle %0d)", name, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem_arr [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  int            ready_delay = 0;
  bit            mem_silent = 1'b0;
  bit            inject_rsp = 1'b0;

  initial begin
    int            valid_age;
    bit            rsp_pend;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] w;
    valid_age = 0;
    rsp_pend  = 1'b0;
    rsp_data  = '0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        if (mem_bus.mem_we) begin
          w = mem_read(mem_bus.mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_bus.mem_wstrb[b]) w[8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
          mem_arr[mem_bus.mem_addr] = w;
          rsp_data = $urandom;  // junk on a store ack; arbiter must return 0
        end else begin
          rsp_data = mem_read(mem_bus.mem_addr);
        end
        rsp_pend = !mem_silent;
      end
      @(posedge clk);
      #1;
      mem_bus.mem_rsp_valid = rsp_pend || inject_rsp;
      mem_bus.mem_rdata     = rsp_pend ? rsp_data : (32'hBAD0_0000 | DW'($urandom_range(1, 255)));
      rsp_pend = 1'b0;
      if (mem_bus.mem_req_valid) valid_age++;
      else valid_age = 0;
      mem_bus.mem_req_ready = mem_bus.mem_req_valid && (valid_age > ready_delay);
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [32:0] exp_if_q[$];   // {err, rdata}
  logic [32:0] exp_ls_q[$];
  logic [68:0] exp_mem_q[$];  // {addr, we, wdata, wstrb}
  int          grant_log[$];  // 0 = fetch, 1 = load/store
  logic [AW-1:0] addr_log[$];
  int if_rsp_count = 0, ls_rsp_count = 0;
  int if_rsp_cyc = 0, ls_rsp_cyc = 0;

  always @(negedge clk) begin
    logic [68:0] fields;
    logic [68:0] prev_fields;
    logic        prev_pending;
    fields = {mem_bus.mem_addr, mem_bus.mem_we, mem_bus.mem_wdata, mem_bus.mem_wstrb};
    if (!reset) begin
      check("ready_exclusive", {127'd0, if_req_ready && ls_req_ready}, 128'd0);
      if (if_req_valid && if_req_ready) grant_log.push_back(0);
      if (ls_req_valid && ls_req_ready) grant_log.push_back(1);
      if (if_rsp_valid) begin
        if_rsp_count++;
        if_rsp_cyc = cyc;
        if (exp_if_q.size() == 0) check_true("if_rsp_unexpected", 1'b0);
        else check("if_rsp", {if_rsp_err, if_rdata}, exp_if_q.pop_front());
      end
      if (ls_rsp_valid) begin
        ls_rsp_count++;
        ls_rsp_cyc = cyc;
        if (exp_ls_q.size() == 0) check_true("ls_rsp_unexpected", 1'b0);
        else check("ls_rsp", {ls_rsp_err, ls_rdata}, exp_ls_q.pop_front());
      end
      if (prev_pending && mem_bus.mem_req_valid) check("mem_fields_stable", fields, prev_fields);
      if (prev_pending) check_true("mem_valid_held", mem_bus.mem_req_valid);
      if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        addr_log.push_back(mem_bus.mem_addr);
        if (exp_mem_q.size() == 0) check_true("mem_issue_unexpected", 1'b0);
        else check("mem_issue", fields, exp_mem_q.pop_front());
      end
      prev_pending = mem_bus.mem_req_valid && !mem_bus.mem_req_ready;
    end else begin
      prev_pending = 1'b0;
    end
    prev_fields = fields;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_req(input logic [AW-1:0] a, output int acc);
    acc = -1;
    if_addr = a;
    if_req_valid = 1'b1;
    for (int i = 0; i < 400 && acc < 0; i++) begin
      @(negedge clk);
      if (if_req_ready) acc = cyc;
    end
    step();
    if_req_valid = 1'b0;
    check_true("if_accept_in_time", acc >= 0);
  endtask

  task automatic ls_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                        input logic [3:0] ws, input int n, output int acc);
    int got;
    got = 0;
    acc = -1;
    ls_addr = a; ls_we = we; ls_wdata = wd; ls_wstrb = ws;
    ls_req_valid = 1'b1;
    for (int i = 0; i < 2000 && got < n; i++) begin
      @(negedge clk);
      if (ls_req_ready) begin
        if (got == 0) acc = cyc;
        got++;
      end
    end
    step();
    ls_req_valid = 1'b0;
    check_true("ls_accept_in_time", got == n);
  endtask

  task automatic wait_rsp(input int if_n, input int ls_n, input int budget);
    int i;
    i = 0;
    while ((if_rsp_count < if_n || ls_rsp_count < ls_n) && i < budget) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    check_true("rsp_in_time", if_rsp_count >= if_n && ls_rsp_count >= ls_n);
  endtask

  // ---------------- directed tests ----------------
  int acc_if, acc_ls, base_if, base_ls;
  int exp_grants [7] = '{1, 1, 1, 1, 0, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_arr[32'h100] = 32'h0000_0013;
    repeat (3) step();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ready", {if_req_ready, ls_req_ready}, 0);
    check("rst_rsp", {if_rsp_valid, if_rsp_err, ls_rsp_valid, ls_rsp_err}, 0);
    check("rst_mem_req", {mem_bus.mem_req_valid, mem_bus.mem_addr, mem_bus.mem_we,
                          mem_bus.mem_wdata, mem_bus.mem_wstrb}, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 0);
    check("rst_state", dbg_state, IDLE);

    // single fetch, minimum latency
    step();
    base_ls = ls_rsp_count;
    exp_mem_q.push_back({32'h100, 1'b0, 32'h0, 4'h0});
    exp_if_q.push_back({1'b0, 32'h0000_0013});
    fetch_req(32'h100, acc_if);
    wait_rsp(1, 0, 20);
    check("fetch_latency", if_rsp_cyc - acc_if, 3);
    check("fetch_no_ls_rsp", ls_rsp_count, base_ls);

    // simultaneous fetch and load: load first, fetch taken in the rsp cycle
    step();
    addr_log.delete();
    exp_mem_q.push_back({32'h200, 1'b0, 32'h0, 4'h0});
    exp_mem_q.push_back({32'h100, 1'b0, 32'h0, 4'h0});
    exp_ls_q.push_back({1'b0, 32'h5A5A_0200});
    exp_if_q.push_back({1'b0, 32'h0000_0013});
    base_if = if_rsp_count; base_ls = ls_rsp_count;
    fork
      fetch_req(32'h100, acc_if);
      ls_req(32'h200, 1'b0, 32'h0, 4'h0, 1, acc_ls);
    join
    wait_rsp(base_if + 1, base_ls + 1, 40);
    check("both_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'h200);
    check("both_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hFFFF_FFFF, 32'h100);
    check("fetch_after_ls_rsp", acc_if, ls_rsp_cyc);

    // starvation guard: four ls grants, then fetch, then ls resumes
    step();
    grant_log.delete();
    for (int i = 0; i < 4; i++) exp_mem_q.push_back({32'h300, 1'b0, 32'h0, 4'h0});
    exp_mem_q.push_back({32'h104, 1'b0, 32'h0, 4'h0});
    for (int i = 0; i < 2; i++) exp_mem_q.push_back({32'h300, 1'b0, 32'h0, 4'h0});
    for (int i = 0; i < 6; i++) exp_ls_q.push_back({1'b0, 32'h5A5A_0300});
    exp_if_q.push_back({1'b0, 32'h5A5A_0104});
    base_if = if_rsp_count; base_ls = ls_rsp_count;
    fork
      fetch_req(32'h104, acc_if);
      ls_req(32'h300, 1'b0, 32'h0, 4'h0, 6, acc_ls);
    join
    wait_rsp(base_if + 1, base_ls + 6, 100);
    check("starve_grant_count", grant_log.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("starve_grant_%0d", i), grant_log.size() > i ? grant_log[i] : 9, exp_grants[i]);

    // store with delayed mem_req_ready
    step();
    ready_delay = 3;
    exp_mem_q.push_back({32'h400, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    exp_ls_q.push_back({1'b0, 32'h0});
    base_ls = ls_rsp_count;
    ls_req(32'h400, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1, acc_ls);
    wait_rsp(0, base_ls + 1, 30);
    check("store_latency", ls_rsp_cyc - acc_ls, 6);
    ready_delay = 0;

    // read back the partially written word
    step();
    exp_mem_q.push_back({32'h400, 1'b0, 32'h0, 4'h0});
    exp_ls_q.push_back({1'b0, 32'h5A5A_BEEF});
    base_ls = ls_rsp_count;
    ls_req(32'h400, 1'b0, 32'h0, 4'h0, 1, acc_ls);
    wait_rsp(0, base_ls + 1, 20);

    // timeout, then a late response that must be ignored
    step();
    mem_silent = 1'b1;
    exp_mem_q.push_back({32'h500, 1'b0, 32'h0, 4'h0});
    exp_ls_q.push_back({1'b1, 32'h0});
    base_ls = ls_rsp_count;
    ls_req(32'h500, 1'b0, 32'h0, 4'h0, 1, acc_ls);
    wait_rsp(0, base_ls + 1, 120);
    check("timeout_latency", ls_rsp_cyc - acc_ls, 66);
    mem_silent = 1'b0;
    base_if = if_rsp_count; base_ls = ls_rsp_count;
    repeat (2) @(negedge clk);
    inject_rsp = 1'b1;
    @(negedge clk);
    inject_rsp = 1'b0;
    repeat (5) @(negedge clk);
    check("late_rsp_ignored", {if_rsp_count, ls_rsp_count}, {base_if, base_ls});
    check("late_rsp_state", dbg_state, IDLE);

    // reset while waiting for a response
    step();
    mem_silent = 1'b1;
    exp_mem_q.push_back({32'h600, 1'b0, 32'h0, 4'h0});
    base_if = if_rsp_count; base_ls = ls_rsp_count;
    fetch_req(32'h600, acc_if);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_rsp", {if_rsp_valid, if_rsp_err, ls_rsp_valid, ls_rsp_err}, 0);
    check("abort_mem", {mem_bus.mem_req_valid, mem_bus.mem_addr, mem_bus.mem_we,
                        mem_bus.mem_wdata, mem_bus.mem_wstrb}, 0);
    check("abort_rdata", {if_rdata, ls_rdata}, 0);
    check("abort_state", dbg_state, IDLE);
    mem_silent = 1'b0;
    inject_rsp = 1'b1;
    @(negedge clk);
    inject_rsp = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_rsp", {if_rsp_count, ls_rsp_count}, {base_if, base_ls});

    // normal fetch after reset
    step();
    exp_mem_q.push_back({32'h100, 1'b0, 32'h0, 4'h0});
    exp_if_q.push_back({1'b0, 32'h0000_0013});
    fetch_req(32'h100, acc_if);
    wait_rsp(base_if + 1, 0, 20);
    check("post_reset_latency", if_rsp_cyc - acc_if, 3);

    repeat (3) @(negedge clk);
    check("queues_drained", {exp_if_q.size(), exp_ls_q.size(), exp_mem_q.size()}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
